// File: rtl/demux_8ch_reg.sv
// 1-to-8 registered demultiplexer: steers one data word into one of eight
// holding registers, each drained by its own valid/ready consumer.
module demux_8ch_reg #(
    parameter int DATA_WIDTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [DATA_WIDTH-1:0]   in_data,
    input  logic [2:0]              in_sel,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [8*DATA_WIDTH-1:0] out_data,
    output logic [7:0]              out_valid,
    input  logic [7:0]              out_ready,
    output logic [3:0]              occ_count
);

    logic [DATA_WIDTH-1:0] hold_r [0:7];
    logic [7:0]            v_r;
    logic [3:0]            occ_r;

    logic                  acc_s;
    logic [7:0]            dr_s;
    logic [7:0]            load_s;
    logic [7:0]            v_next_s;
    logic [3:0]            occ_next_s;

    function automatic logic [3:0] popcount8(input logic [7:0] bits);
        logic [3:0] cnt;
        cnt = 4'd0;
        for (int i = 0; i < 8; i++) begin
            cnt = cnt + {3'b000, bits[i]};
        end
        return cnt;
    endfunction

    // A full destination can still take a word when its consumer drains it this cycle.
    assign in_ready = ~v_r[in_sel] | out_ready[in_sel];

    // Accept/drain decode and next-state occupancy.
    always_comb begin
        acc_s  = in_valid & in_ready;
        dr_s   = v_r & out_ready;
        load_s = 8'h00;
        if (acc_s) begin
            load_s = 8'h01 << in_sel;
        end else begin
            load_s = 8'h00;
        end
        // A load wins over a drain on the same channel, so v stays set.
        v_next_s   = (v_r & ~dr_s) | load_s;
        occ_next_s = popcount8(v_next_s);
    end

    // Channel flags, holding registers and occupancy count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_r   <= 8'h00;
            occ_r <= 4'd0;
            for (int k = 0; k < 8; k++) begin
                hold_r[k] <= '0;
            end
        end else begin
            v_r   <= v_next_s;
            occ_r <= occ_next_s;
            for (int k = 0; k < 8; k++) begin
                if (load_s[k]) begin
                    hold_r[k] <= in_data;
                end
            end
        end
    end

    genvar g;
    generate
        for (g = 0; g < 8; g++) begin : g_slice
            assign out_data[g*DATA_WIDTH +: DATA_WIDTH] = hold_r[g];
        end
    endgenerate

    assign out_valid = v_r;
    assign occ_count = occ_r;

endmodule

// File: tb/tb_demux_8ch_reg.sv
// Self-checking bench for demux_8ch_reg: directed scenarios plus random
// traffic compared against a per-channel array model.
module tb_demux_8ch_reg;

    localparam int DW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic [2:0]    in_sel = 3'd0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [8*DW-1:0] out_data;
    logic [7:0]    out_valid;
    logic [7:0]    out_ready = 8'h00;
    logic [3:0]    occ_count;

    int errors = 0;
    int checks = 0;

    // Reference model: what each channel holds and whether it is occupied.
    logic [DW-1:0] m_hold [8];
    bit            m_v    [8];

    demux_8ch_reg #(.DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_sel(in_sel),
        .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready), .occ_count(occ_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 8; k++) begin
            m_hold[k] = '0;
            m_v[k] = 1'b0;
        end
    endtask

    function automatic bit model_ready(input logic [2:0] sel, input logic [7:0] ordy);
        return !m_v[sel] || ordy[sel];
    endfunction

    task automatic check_outputs(input string tag);
        logic [8*DW-1:0] exp_data;
        logic [7:0] exp_v;
        int cnt;
        cnt = 0;
        for (int k = 0; k < 8; k++) begin
            exp_data[k*DW +: DW] = m_hold[k];
            exp_v[k] = m_v[k];
            cnt += int'(m_v[k]);
        end
        check({tag, ".valid"}, 64'(out_valid), 64'(exp_v));
        check({tag, ".occ"},   64'(occ_count), 64'(cnt));
        check({tag, ".data"},  64'(out_data),  64'(exp_data));
    endtask

    // Drive one cycle of stimulus (called at a falling edge), check ready,
    // advance the model with the clock, then check registered outputs.
    task automatic step(input bit valid, input logic [2:0] sel, input logic [DW-1:0] data,
                        input logic [7:0] ordy, input string tag);
        bit rdy;
        in_valid = valid; in_sel = sel; in_data = data; out_ready = ordy;
        #1;
        rdy = model_ready(sel, ordy);
        check({tag, ".in_ready"}, 64'(in_ready), 64'(rdy));
        @(posedge clk);
        for (int k = 0; k < 8; k++) begin
            if (m_v[k] && ordy[k]) m_v[k] = 1'b0;
        end
        if (valid && rdy) begin
            m_hold[sel] = data;
            m_v[sel] = 1'b1;
        end
        @(negedge clk);
        check_outputs(tag);
    endtask

    initial begin
        model_reset();
        // Reset with no clock edge yet.
        #1 rst = 1'b1;
        #2;
        check("rst.valid", 64'(out_valid), 64'h00);
        check("rst.occ",   64'(occ_count), 64'h0);
        check("rst.data",  64'(out_data),  64'h0);
        check("rst.in_ready", 64'(in_ready), 64'h1);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 5; i++) step(1'b0, 3'(i), 4'hF, 8'h00, "idle");

        // Single route.
        step(1'b1, 3'd5, 4'hA, 8'h00, "route");
        check("route.valid_const", 64'(out_valid), 64'h20);
        check("route.slice5", 64'(out_data[5*DW +: DW]), 64'hA);

        // Backpressure, then same-cycle drain and reload.
        step(1'b1, 3'd5, 4'h3, 8'h00, "bp_stall");
        check("bp_stall.slice5", 64'(out_data[5*DW +: DW]), 64'hA);
        step(1'b1, 3'd5, 4'h3, 8'h20, "bp_swap");
        check("bp_swap.slice5", 64'(out_data[5*DW +: DW]), 64'h3);
        check("bp_swap.occ_const", 64'(occ_count), 64'h1);

        // Empty everything, then fill all eight.
        step(1'b0, 3'd0, 4'h0, 8'hFF, "drain_all");
        for (int k = 0; k < 8; k++) step(1'b1, 3'(k), 4'(k + 1), 8'h00, "fill");
        check("fill.valid_const", 64'(out_valid), 64'hFF);
        check("fill.occ_const",   64'(occ_count), 64'h8);
        step(1'b1, 3'd2, 4'hE, 8'h00, "full_stall");
        check("full_stall.occ_const", 64'(occ_count), 64'h8);

        // Parallel drain of 0 and 7 with a load into 3.
        step(1'b0, 3'd0, 4'h0, 8'h7E, "keep_0_7");
        step(1'b1, 3'd3, 4'h9, 8'h81, "par");
        check("par.valid_const", 64'(out_valid), 64'h08);
        check("par.occ_const",   64'(occ_count), 64'h1);
        check("par.slice0_stale", 64'(out_data[0 +: DW]), 64'h1);

        // Async reset mid-stream.
        step(1'b1, 3'd0, 4'h4, 8'h00, "pre_rst");
        step(1'b1, 3'd1, 4'h5, 8'h00, "pre_rst");
        step(1'b1, 3'd2, 4'h6, 8'h00, "pre_rst");
        check("pre_rst.occ_const", 64'(occ_count), 64'h4);
        in_valid = 1'b0; out_ready = 8'h00;
        #2 rst = 1'b1;
        #1;
        check("async_rst.valid", 64'(out_valid), 64'h00);
        check("async_rst.occ",   64'(occ_count), 64'h0);
        check("async_rst.data",  64'(out_data),  64'h0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        step(1'b1, 3'd1, 4'hC, 8'h00, "post_rst");
        check("post_rst.occ_const", 64'(occ_count), 64'h1);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 3) != 0), 3'($urandom), 4'($urandom),
                 8'($urandom), "rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/demux_8ch_reg.md
Name: demux_8ch_reg

Overview:
- Write-side counterpart of the ALU 8:1 result selector: a 1-to-8 registered demultiplexer.
- Takes one data word plus a 3-bit destination select and steers it into one of eight per-channel holding registers.
- Each channel presents its data to a downstream consumer with a valid/ready handshake.
- Sits between the ALU result bus and eight destination consumers (register slots / operand latches).

Parameters:
DATA_WIDTH, 4, width of data word and of each channel holding register

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  asynchronous, active-high reset
in_data  input  DATA_WIDTH  word to distribute
in_sel  input  3  destination channel index 0..7
in_valid  input  1  producer offers in_data/in_sel this cycle
in_ready  output  1  block accepts the offered word this cycle (combinational)
out_data  output  8*DATA_WIDTH  channel k data at bits [k*DATA_WIDTH +: DATA_WIDTH]
out_valid  output  8  bit k = channel k holds an unconsumed word
out_ready  input  8  bit k = consumer k takes channel k data this cycle
occ_count  output  4  number of channels with out_valid set, 0..8

Behaviour:
- Reset (asynchronous, rst=1): out_valid=8'h00, all out_data=0, occ_count=0. in_ready follows its combinational equation, so in_ready=1 during reset. No transfer is recorded while rst=1.
- Per-channel state is one holding register hold[k] and one flag v[k]. out_data slice k = hold[k]; out_valid[k] = v[k]; both are registered outputs.
- in_ready = ~v[in_sel] | out_ready[in_sel].
  - in_ready depends on in_sel and out_ready only, never on in_valid.
  - in_sel is evaluated every cycle, including cycles with in_valid=0.
- Accept: acc = in_valid & in_ready. On acc, the next edge gives hold[in_sel] <= in_data and v[in_sel] <= 1. Input-to-output latency is 1 cycle.
- Drain: dr[k] = v[k] & out_ready[k]. On dr[k] without a load into k, the next edge gives v[k] <= 0. hold[k] keeps its stale value; it is not cleared.
- Simultaneous load and drain on the same channel k (acc, in_sel=k, dr[k]): the old word is consumed this cycle, the new word is loaded, and v[k] stays 1. No bubble, no loss.
- Full channel, no drain (v[k]=1, out_ready[k]=0, in_sel=k): in_ready=0 and no state change. The producer must hold in_data/in_sel stable until accepted.
- Other channels are unaffected by a stall on channel k. Drains on any channels happen in parallel with a load to a different channel.
- out_ready[k] while v[k]=0 has no effect.
- occ_count is registered and equals the popcount of next-state v:
  - +1 on a load into an empty channel.
  - -1 on a drain without a reload.
  - Unchanged on a simultaneous load and drain of the same channel.
  - Never exceeds 8 and never wraps.
- Reset asserted mid-operation immediately clears all v and zeroes data and occ_count. In-flight words are discarded, with no partial updates after rst deasserts.
- Width rule: data passes through unmodified. No truncation or extension.

Test Plan:
- Reset then idle: rst=1 -> out_valid=00, occ_count=0, out_data all 0. Release rst, in_valid=0 for 5 cycles -> no change.
- Single route: in_sel=5, in_data=4'hA, in_valid=1 for one cycle, all out_ready=0 -> next cycle out_valid=8'h20, slice 5=4'hA, occ_count=1. Other slices stay 0.
- Backpressure: channel 5 full with 4'hA, out_ready=0, offer in_sel=5, data 4'h3 -> in_ready=0 and slice 5 stays 4'hA. Raise out_ready[5] -> in_ready=1 in the same cycle. Next edge: slice 5=4'h3, out_valid[5]=1, occ_count stays 1.
- Fill all: load channels 0..7 with data k+1 on consecutive cycles, no drains -> occ_count reaches 8, out_valid=FF. A further offer to in_sel=2 -> in_ready=0.
- Parallel drain and load: channels 0 and 7 full, out_ready=8'h81, load in_sel=3 data 4'h9 in the same cycle -> out_valid=8'h08, occ_count=1, slice 0 keeps its stale value.
- Async reset mid-stream: with occ_count=4, assert rst between clock edges -> out_valid=00, occ_count=0 immediately (no edge needed). After release, the first load to channel 1 gives occ_count=1.
